// File: rtl/mac_dot_accumulator_pkg.sv
// Shared definitions for the MAC dot-product accumulator.
//   state_t : FSM state encoding (IDLE, ACCUM, DONE)
//   PROD_W  : width of the 4x4 multiplier product
//   OPND_W  : width of each multiplier operand
package mac_dot_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PROD_W = 8;
    localparam int OPND_W = 4;

endpackage

// File: rtl/mac_dot_accumulator_mult.sv
// 4-bit unsigned array multiplier built from half and full adders.
// Ports:
//   a       [3:0] in  : multiplicand
//   b       [3:0] in  : multiplier
//   product [7:0] out : a * b, purely combinational
// Each row adds the next partial product (a & b[i]) to the previous row's
// sum shifted right by one; the dropped LSB of every row is a final
// product bit and the last row supplies the upper five bits.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module fa_ha_multiplier_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);
    logic [3:0][3:0] row_sum;
    logic [3:0]      row_cout;
    logic [3:1][4:1] carry;

    assign row_sum[0]  = a & {4{b[0]}};
    assign row_cout[0] = 1'b0;

    for (genvar i = 1; i < 4; i++) begin : g_row
        logic [3:0] x;
        logic [3:0] y;
        assign x = {row_cout[i-1], row_sum[i-1][3:1]};
        assign y = a & {4{b[i]}};

        half_adder u_ha (
            .x (x[0]),
            .y (y[0]),
            .s (row_sum[i][0]),
            .c (carry[i][1])
        );

        for (genvar j = 1; j < 4; j++) begin : g_bit
            full_adder u_fa (
                .x  (x[j]),
                .y  (y[j]),
                .ci (carry[i][j]),
                .s  (row_sum[i][j]),
                .co (carry[i][j+1])
            );
        end

        assign row_cout[i] = carry[i][4];
    end

    assign product = {row_cout[3], row_sum[3], row_sum[2][0], row_sum[1][0], row_sum[0][0]};
endmodule

// File: rtl/mac_dot_accumulator.sv
// Multiply-accumulate stage: accepts N_TERMS operand pairs, multiplies each
// in the 4-bit array multiplier and sums the products into a saturating
// ACC_W-bit dot-product result.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin a new dot product (only honoured in IDLE)
//   in_valid/in_ready     : operand-pair handshake, a/b operands
//   out_valid/out_ready   : result handshake
//   acc                   : accumulated result (held until the next start)
//   ovf                   : sticky saturation flag for the current dot product
//   busy                  : high in ACCUM and DONE
//   state                 : current FSM state, for observation
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and out_valid stays high with acc
// stable until out_ready is seen.
module mac_dot_accumulator
    import mac_dot_accumulator_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf,
    output logic              busy,
    output state_t            state
);

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt;
    logic               s1_valid;
    logic [OPND_W-1:0]  s1_a;
    logic [OPND_W-1:0]  s1_b;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   acc_r;
    logic               ovf_r;
    logic [ACC_W:0]     sum;
    logic               sat;
    logic               take;

    fa_ha_multiplier_4bit u_fa_ha_multiplier_4bit (
        .a       (s1_a),
        .b       (s1_b),
        .product (prod)
    );

    // One extra bit catches the carry out of the accumulator; once ovf is
    // set the result is pinned at all ones for the rest of the dot product.
    assign sum  = {1'b0, acc_r} + (ACC_W+1)'(prod);
    assign sat  = sum[ACC_W] | ovf_r;

    assign in_ready  = (state_r == ACCUM) && (cnt < N_LAST);
    assign take      = in_valid & in_ready;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign acc       = acc_r;
    assign ovf       = ovf_r;
    assign state     = state_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            acc_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r    <= '0;
                        ovf_r    <= 1'b0;
                        cnt      <= '0;
                        s1_valid <= 1'b0;
                        state_r  <= ACCUM;
                    end
                end
                ACCUM: begin
                    s1_valid <= take;
                    if (take) begin
                        s1_a <= a;
                        s1_b <= b;
                        cnt  <= cnt + CNT_W'(1);
                    end
                    if (s1_valid) begin
                        if (sat) begin
                            acc_r <= '1;
                            ovf_r <= 1'b1;
                        end else begin
                            acc_r <= sum[ACC_W-1:0];
                        end
                        // The counter already counts the pair being added,
                        // so reaching N_LAST here means this is the last add.
                        if (cnt == N_LAST) begin
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_accumulator.sv
module tb_mac_dot_accumulator;
    import mac_dot_accumulator_pkg::*;

    logic        clk;
    logic        rst_n;

    // main instance: N_TERMS=4, ACC_W=12
    logic        start, in_valid, out_ready;
    logic [3:0]  a, b;
    logic        in_ready, out_valid, ovf, busy;
    logic [11:0] acc;
    state_t      state;

    // saturation instance: N_TERMS=2, ACC_W=8
    logic        s_start, s_in_valid, s_out_ready;
    logic [3:0]  s_a, s_b;
    logic        s_in_ready, s_out_valid, s_ovf, s_busy;
    logic [7:0]  s_acc;
    state_t      s_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [3:0]  pa [4] = '{4'd3, 4'd5, 4'd15, 4'd1};
    logic [3:0]  pb [4] = '{4'd5, 4'd10, 4'd15, 4'd1};
    logic [11:0] part [4] = '{12'd0, 12'd15, 12'd65, 12'd290};

    mac_dot_accumulator #(.N_TERMS(4), .ACC_W(12), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .acc(acc), .ovf(ovf), .busy(busy), .state(state)
    );

    mac_dot_accumulator #(.N_TERMS(2), .ACC_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .a(s_a), .b(s_b), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .acc(s_acc), .ovf(s_ovf), .busy(s_busy), .state(s_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; in_valid = 0; out_ready = 1; a = 0; b = 0;
        s_start = 0; s_in_valid = 0; s_out_ready = 1; s_a = 0; s_b = 0;
        #12;
        vec_cnt++; if (acc !== 12'd0 || ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_acc: got acc=%0d ovf=%0b, want 0/0", acc, ovf); end
        vec_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL reset_flags: got ov=%0b ir=%0b busy=%0b, want 0/0/0", out_valid, in_ready, busy); end
        vec_cnt++; if (state !== IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d, want %0d", state, IDLE); end
        rst_n = 1'b1;
        tick();
        in_valid = 1; a = 4'd9; b = 4'd9;
        tick();
        vec_cnt++; if (in_ready !== 1'b0 || acc !== 12'd0 || state !== IDLE) begin err_cnt++; $display("FAIL idle_in_valid: got ir=%0b acc=%0d st=%0d, want 0/0/IDLE", in_ready, acc, state); end
        in_valid = 0;
    endtask

    task automatic test_basic();
        out_ready = 1;
        pulse_start();
        vec_cnt++; if (state !== ACCUM || acc !== 12'd0 || in_ready !== 1'b1 || busy !== 1'b1) begin err_cnt++; $display("FAIL basic_start: got st=%0d acc=%0d ir=%0b busy=%0b, want ACCUM/0/1/1", state, acc, in_ready, busy); end
        for (int k = 0; k < 4; k++) begin
            a = pa[k]; b = pb[k]; in_valid = 1;
            tick();
            vec_cnt++; if (acc !== part[k]) begin err_cnt++; $display("FAIL basic_latency_%0d: got acc=%0d, want %0d", k, acc, part[k]); end
        end
        in_valid = 0;
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL basic_ready_drop: got %0b, want 0", in_ready); end
        tick();
        vec_cnt++; if (acc !== 12'd291 || ovf !== 1'b0 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_result: got acc=%0d ovf=%0b ov=%0b, want 291/0/1", acc, ovf, out_valid); end
        tick();
        vec_cnt++; if (out_valid !== 1'b0 || state !== IDLE || acc !== 12'd291) begin err_cnt++; $display("FAIL basic_pulse: got ov=%0b st=%0d acc=%0d, want 0/IDLE/291", out_valid, state, acc); end
    endtask

    task automatic test_gaps();
        out_ready = 1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL gaps_ready_%0d: got 0, want 1", k); end
            a = pa[k]; b = pb[k]; in_valid = 1;
            tick();
            in_valid = 0;
            if (k < 3) begin
                tick();
                tick();
            end
        end
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL gaps_ready_drop: got 1, want 0"); end
        tick();
        vec_cnt++; if (acc !== 12'd291 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL gaps_result: got acc=%0d ov=%0b, want 291/1", acc, out_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            a = pa[k]; b = pb[k]; in_valid = 1;
            tick();
        end
        in_valid = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            vec_cnt++; if (out_valid !== 1'b1 || acc !== 12'd291 || state !== DONE) begin err_cnt++; $display("FAIL bp_hold_%0d: got ov=%0b acc=%0d st=%0d, want 1/291/DONE", k, out_valid, acc, state); end
        end
        out_ready = 1;
        tick();
        vec_cnt++; if (state !== IDLE || out_valid !== 1'b0 || acc !== 12'd291) begin err_cnt++; $display("FAIL bp_release: got st=%0d ov=%0b acc=%0d, want IDLE/0/291", state, out_valid, acc); end
    endtask

    task automatic test_ignored_start();
        out_ready = 1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            a = pa[k]; b = pb[k]; in_valid = 1;
            start = (k == 2);
            tick();
        end
        start = 0; in_valid = 0;
        tick();
        vec_cnt++; if (acc !== 12'd291 || state !== DONE) begin err_cnt++; $display("FAIL ign_start: got acc=%0d st=%0d, want 291/DONE", acc, state); end
        tick();
        in_valid = 1; a = 4'd7; b = 4'd7;
        tick();
        tick();
        vec_cnt++; if (in_ready !== 1'b0 || acc !== 12'd291 || state !== IDLE || busy !== 1'b0) begin err_cnt++; $display("FAIL ign_in_valid: got ir=%0b acc=%0d st=%0d busy=%0b, want 0/291/IDLE/0", in_ready, acc, state, busy); end
        in_valid = 0;
    endtask

    task automatic test_saturation();
        s_out_ready = 1;
        s_start = 1; tick(); s_start = 0;
        s_a = 4'd15; s_b = 4'd15; s_in_valid = 1;
        tick();
        tick();
        s_in_valid = 0;
        vec_cnt++; if (s_acc !== 8'd225 || s_ovf !== 1'b0 || s_in_ready !== 1'b0) begin err_cnt++; $display("FAIL sat_first: got acc=%0d ovf=%0b ir=%0b, want 225/0/0", s_acc, s_ovf, s_in_ready); end
        tick();
        vec_cnt++; if (s_acc !== 8'd255 || s_ovf !== 1'b1 || s_out_valid !== 1'b1) begin err_cnt++; $display("FAIL sat_result: got acc=%0d ovf=%0b ov=%0b, want 255/1/1", s_acc, s_ovf, s_out_valid); end
        tick();
        vec_cnt++; if (s_state !== IDLE || s_acc !== 8'd255 || s_ovf !== 1'b1) begin err_cnt++; $display("FAIL sat_hold: got st=%0d acc=%0d ovf=%0b, want IDLE/255/1", s_state, s_acc, s_ovf); end
        s_start = 1; tick(); s_start = 0;
        vec_cnt++; if (s_acc !== 8'd0 || s_ovf !== 1'b0 || s_state !== ACCUM) begin err_cnt++; $display("FAIL sat_restart: got acc=%0d ovf=%0b st=%0d, want 0/0/ACCUM", s_acc, s_ovf, s_state); end
        // exact fit: 15*15 + 5*6 = 255 stays unsaturated
        s_a = 4'd15; s_b = 4'd15; s_in_valid = 1; tick();
        s_a = 4'd5;  s_b = 4'd6;  tick();
        s_in_valid = 0; tick();
        vec_cnt++; if (s_acc !== 8'd255 || s_ovf !== 1'b0 || s_out_valid !== 1'b1) begin err_cnt++; $display("FAIL sat_edge: got acc=%0d ovf=%0b ov=%0b, want 255/0/1", s_acc, s_ovf, s_out_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1;
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            a = pa[k]; b = pb[k]; in_valid = 1;
            tick();
        end
        #2;
        rst_n = 0;
        #1;
        vec_cnt++; if (acc !== 12'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || state !== IDLE) begin err_cnt++; $display("FAIL rst_mid: got acc=%0d ov=%0b ir=%0b st=%0d, want 0/0/0/IDLE", acc, out_valid, in_ready, state); end
        in_valid = 0;
        tick();
        #2;
        rst_n = 1;
        tick();
        pulse_start();
        a = 4'd2;  b = 4'd3; in_valid = 1; tick();
        a = 4'd4;  b = 4'd4; tick();
        a = 4'd0;  b = 4'd9; tick();
        a = 4'd15; b = 4'd1; tick();
        in_valid = 0;
        tick();
        vec_cnt++; if (acc !== 12'd37 || out_valid !== 1'b1 || ovf !== 1'b0) begin err_cnt++; $display("FAIL rst_fresh: got acc=%0d ov=%0b ovf=%0b, want 37/1/0", acc, out_valid, ovf); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_ignored_start();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
